// File: rtl/stream_mux_arbiter_pkg.sv
// Shared constants and helpers for the stream mux/arbiter slice.
// Imported by the top and the round-robin picker.
package stream_mux_arbiter_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_grant_picker.sv
// Round-robin grant picker: first set request at or after ptr.
// Pure combinational rotate-then-priority-encode.
module rr_grant_picker
  import stream_mux_arbiter_pkg::*;
#(
  parameter int M    = 4,
  parameter int SELW = $clog2(M)
) (
  input  logic [M-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic            found,
  output logic [SELW-1:0] idx
);

  logic [2*M-1:0] dbl;
  logic [M-1:0]   rot;
  logic [SELW:0]  sum;

  assign dbl = {req, req} >> ptr;
  assign rot = dbl[M-1:0];

  // Scan high to low so the lowest rotated hit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    sum   = '0;
    for (int j = M - 1; j >= 0; j--) begin
      if (rot[j]) begin
        sum = {1'b0, ptr} + (SELW + 1)'(j);
        if (sum >= (SELW + 1)'(M))
          sum = sum - (SELW + 1)'(M);
        found = 1'b1;
        idx   = sum[SELW-1:0];
      end
    end
  end

endmodule

// File: rtl/stream_mux_arbiter.sv
// M-channel valid/ready stream mux with fixed or round-robin grant
// and a single registered output stage.
module stream_mux_arbiter
  import stream_mux_arbiter_pkg::*;
#(
  parameter int N    = 8,
  parameter int M    = 4,
  parameter int SELW = $clog2(M)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            mode,
  input  logic [SELW-1:0] sel,
  input  logic [M*N-1:0]  y,
  input  logic [M-1:0]    y_valid,
  output logic [M-1:0]    y_ready,
  output logic [N-1:0]    f,
  output logic            f_valid,
  input  logic            f_ready,
  output logic [SELW-1:0] f_ch
);

  logic [SELW-1:0] ptr;
  logic            rr_found;
  logic [SELW-1:0] rr_idx;
  logic            fx_found;
  logic            grant_found;
  logic [SELW-1:0] g;
  logic [SELW-1:0] gi;
  logic [SELW-1:0] nxt_ptr;
  logic            load;
  logic            fire;
  logic [N-1:0]    din;

  rr_grant_picker #(
    .M    (M),
    .SELW (SELW)
  ) u_pick (
    .req   (y_valid),
    .ptr   (ptr),
    .found (rr_found),
    .idx   (rr_idx)
  );

  // Out-of-range sel matches no k, so it never grants.
  always_comb begin
    fx_found = 1'b0;
    for (int k = 0; k < M; k++)
      if (sel == SELW'(k) && y_valid[k])
        fx_found = 1'b1;
  end

  always_comb begin
    grant_found = 1'b0;
    g           = '0;
    unique case (mode)
      MODE_FIXED: begin
        grant_found = fx_found;
        g           = sel;
      end
      MODE_RR: begin
        grant_found = rr_found;
        g           = rr_idx;
      end
      default: ;
    endcase
  end

  assign load = !f_valid || f_ready;
  assign fire = resetn && load && grant_found;

  assign y_ready = fire
    ? ({{(M-1){1'b0}}, 1'b1} << g)
    : '0;

  assign gi  = grant_found ? g : '0;
  assign din = y[int'(gi)*N +: N];

  assign nxt_ptr = (g == SELW'(M - 1))
    ? '0
    : g + 1'b1;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      f       <= '0;
      f_valid <= 1'b0;
      f_ch    <= '0;
      ptr     <= '0;
    end else if (fire) begin
      f       <= din;
      f_ch    <= g;
      f_valid <= 1'b1;
      if (mode == MODE_RR)
        ptr <= nxt_ptr;
    end else if (f_ready) begin
      f_valid <= 1'b0;
    end
  end

endmodule
